mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised MEM pipeline stage, successor of the single-cycle MEM block. Sits between EX and WB.
//  Handles all MIPS load/store forms, including LWL/LWR/SWL/SWR, using per-byte write enables.
//  Talks to data memory over a variable-latency req/gnt/rvalid handshake and posts stores to a store buffer.
//  Asserts STALL_OUT to freeze upstream stages while an access cannot complete.
// PARAMETERS
//  SB_DEPTH    4   store-buffer entries (power of 2, >=2)
//  BIG_ENDIAN  1   1: byte offset 0 = bits[31:24]; 0: byte offset 0 = bits[7:0]
//  ADDR_W      32  address width; data width fixed at 32 (ISA)
// PORTS
//  CLK                 in   1       clock, all state on posedge
//  RESET               in   1       synchronous, active-high
//  Instr1_IN           in   32      instruction (debug, piped through)
//  Instr1_PC_IN        in   32      PC (debug, piped through)
//  ALU_result1_IN      in   ADDR_W  effective address, or result for non-memory ops
//  WriteRegister1_IN   in   5       destination register
//  MemWriteData1_IN    in   32      rt value: store data, and merge source for LWL/LWR
//  RegWrite1_IN        in   1       instruction writes a register
//  ALU_Control1_IN     in   6       memory-op encoding (package constants)
//  MemRead1_IN         in   1       load
//  MemWrite1_IN        in   1       store
//  WriteRegister1_OUT  out  5       to WB
//  RegWrite1_OUT       out  1       to WB
//  WriteData1_OUT      out  32      to WB
//  STALL_OUT           out  1       hold EX/MEM inputs stable this cycle
//  AddrError_OUT       out  1       1-cycle pulse: misaligned LH/LHU/SH/LW/SW/LL/SC/LWC1
//  data_address_2DM    out  ADDR_W  word-aligned address
//  data_write_2DM      out  32      lane-positioned write data
//  data_byte_en_2DM    out  4       byte enables; bit3 = bits[31:24]
//  MemRead_2DM         out  1       read request
//  MemWrite_2DM        out  1       write request
//  data_gnt_fDM        in   1       request accepted this cycle
//  data_rvalid_fDM     in   1       data_read_fDM valid this cycle
//  data_read_fDM       in   32      read data
// BEHAVIOUR
//  Reset: FSM=IDLE, SB empty, all outputs 0.
//   RESET mid-access drops the transaction; a later rvalid is ignored unless FSM=LD_WAIT.
//  FSM IDLE -> LD_DRAIN -> LD_REQ -> LD_WAIT -> IDLE.
//   A load in IDLE with SB nonempty goes to LD_DRAIN; with SB empty it goes directly to LD_REQ.
//   LD_REQ holds MemRead_2DM and the address stable until gnt.
//   On gnt -> LD_WAIT; when gnt and rvalid arrive in the same cycle, the load completes in that cycle.
//  Load latency: zero-wait memory with SB empty completes in 1 cycle with no stall.
//   Otherwise STALL_OUT=1 every cycle until the rvalid cycle, which has STALL_OUT=0.
//  Store: enqueue {word addr, lane data, byte_en} when not full; STALL_OUT=0.
//   SB full -> STALL_OUT=1 until a pop.
//   Pop and push in the same cycle are legal when full.
//  SB drain: head presented with MemWrite_2DM whenever FSM is not LD_REQ/LD_WAIT; pop on gnt. FIFO order.
//   MemRead_2DM and MemWrite_2DM are never both 1.
//  Output register loads only when STALL_OUT=0.
//   During a stall it loads a bubble: RegWrite1_OUT=0.
//  Non-memory op: WriteData1_OUT <= ALU_result1_IN.
//  SC: store, and WriteData1_OUT <= 1.
//  Misalignment: no access, RegWrite1_OUT=0, AddrError_OUT=1.
//  Alignment rules (big-endian, offset k = addr[1:0], w = memory word, r = rt):
//   LB/LBU: byte k, sign- or zero-extended.
//   LH/LHU: half k/2, sign- or zero-extended.
//   LWL: k=0 w | k=1 {w[23:0],r[7:0]} | k=2 {w[15:0],r[15:0]} | k=3 {w[7:0],r[23:0]}
//   LWR: k=0 {r[31:8],w[31:24]} | k=1 {r[31:16],w[31:16]} | k=2 {r[31:24],w[31:8]} | k=3 w
//   SB: be = one-hot of byte k.   SH: be = 1100 or 0011.   SW/SC: be = 1111.
//   SWL: be = 1111>>k, data = r>>(8k).
//   SWR: be = 1111<<(3-k), data = r<<(8(3-k)).
//   BIG_ENDIAN=0 mirrors the byte-lane mapping.
// STRUCTURE
//  Package mem_pkg: ALU_Control encodings:
//   LB 100001, LH 101011, LBU 101010, LHU 101100, LW 111101, LL 101000, LWC1 110101,
//   LWL 101101, LWR 101110, SB 101111, SH 110000, SW 110001, SC 110110, SWL 110010, SWR 110011;
//   plus the FSM state typedef.
//  Sub-module mem_store_buffer: synchronous FIFO, SB_DEPTH x {ADDR_W-2, 32, 4}, full/empty flags.
//  Alignment and merge logic is combinational inside mem_access_unit.
// TESTING
//  1. SW 0xDEADBEEF @0x100, then LW @0x100, memory latency 3.
//     -> write drains first; LW returns 0xDEADBEEF; STALL_OUT high for exactly the drain + read cycles.
//  2. LB @0x103, word 0x112233F0 -> 0xFFFFFFF0. LBU same address -> 0x000000F0.
//     LH @0x102 -> 0x000033F0 sign-extended = 0x000033F0.
//  3. LWL @0x101, rt=0xAAAAAAAA, word 0x11223344 -> 0x223344AA.
//     LWR @0x101, rt=0xAAAAAAAA, same word -> 0xAAAA1122.
//  4. SWL @0x102, rt=0x55667788 -> be=0011, data=0x00005566.
//     SWR @0x101, rt=0x55667788 -> be=1100, data=0x77880000.
//  5. Five back-to-back SW with gnt held low -> STALL_OUT on the 5th.
//     Raise gnt for one cycle -> push and pop in the same cycle, STALL_OUT drops.
//  6. LH @0x101 -> AddrError_OUT pulse, no DM request, RegWrite1_OUT=0.
//     RESET in LD_WAIT, then a late rvalid -> ignored, outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Purpose: shared constants for the MEM stage: ALU_Control memory-op
// encodings, FSM state encoding and byte-lane helper functions.
package mem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   // Memory-op encodings carried on ALU_Control
   localparam logic [5:0] OP_LB   = 6'b100001;
   localparam logic [5:0] OP_LH   = 6'b101011;
   localparam logic [5:0] OP_LBU  = 6'b101010;
   localparam logic [5:0] OP_LHU  = 6'b101100;
   localparam logic [5:0] OP_LW   = 6'b111101;
   localparam logic [5:0] OP_LL   = 6'b101000;
   localparam logic [5:0] OP_LWC1 = 6'b110101;
   localparam logic [5:0] OP_LWL  = 6'b101101;
   localparam logic [5:0] OP_LWR  = 6'b101110;
   localparam logic [5:0] OP_SB   = 6'b101111;
   localparam logic [5:0] OP_SH   = 6'b110000;
   localparam logic [5:0] OP_SW   = 6'b110001;
   localparam logic [5:0] OP_SC   = 6'b110110;
   localparam logic [5:0] OP_SWL  = 6'b110010;
   localparam logic [5:0] OP_SWR  = 6'b110011;

   // Load-sequencing FSM
   typedef logic [1:0] mem_state_t;
   localparam mem_state_t ST_IDLE     = 2'd0;
   localparam mem_state_t ST_LD_DRAIN = 2'd1;
   localparam mem_state_t ST_LD_REQ   = 2'd2;
   localparam mem_state_t ST_LD_WAIT  = 2'd3;

   // Reverse byte order (lane mirroring for little-endian builds)
   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [BE_W-1:0] be_swap(input logic [BE_W-1:0] b);
      return {b[0], b[1], b[2], b[3]};
   endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// Purpose: synchronous FIFO of posted stores {word addr, lane data, byte enables}.
// Ports: CLK/RESET (sync, active-high); push/pop strobes; push_* entry in;
//        head_* oldest entry out; full/empty flags.
// Caller guarantees push only when !full or popping, pop only when !empty.
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 30
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              push,
   input  logic [AW-1:0]     push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic [BE_W-1:0]   push_be,
   input  logic              pop,
   output logic [AW-1:0]     head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [BE_W-1:0]   head_be,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AW-1:0]     addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [BE_W-1:0]   be_mem   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   // Pointer and occupancy tracking
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: only slots behind the pointers are read
   always_ff @(posedge CLK) begin
      if (push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
         be_mem[wr_ptr]   <= push_be;
      end
   end

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign head_be   = be_mem[rd_ptr];
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM pipeline stage between EX and WB. Aligns loads (incl. LWL/LWR),
// builds byte-enabled stores (incl. SWL/SWR) posted to a store buffer, and
// sequences data-memory reads over a req/gnt/rvalid handshake.
// Ports: CLK/RESET; EX-side *1_IN bundle; WB-side *1_OUT registers;
//        STALL_OUT (combinational hold request); AddrError_OUT (registered pulse);
//        *_2DM request to data memory; *_fDM responses from data memory.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned SB_DEPTH   = 4,
   parameter bit          BIG_ENDIAN = 1'b1,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       Instr1_IN,
   input  logic [31:0]       Instr1_PC_IN,
   input  logic [ADDR_W-1:0] ALU_result1_IN,
   input  logic [4:0]        WriteRegister1_IN,
   input  logic [31:0]       MemWriteData1_IN,
   input  logic              RegWrite1_IN,
   input  logic [5:0]        ALU_Control1_IN,
   input  logic              MemRead1_IN,
   input  logic              MemWrite1_IN,
   output logic [4:0]        WriteRegister1_OUT,
   output logic              RegWrite1_OUT,
   output logic [31:0]       WriteData1_OUT,
   output logic              STALL_OUT,
   output logic              AddrError_OUT,
   output logic [ADDR_W-1:0] data_address_2DM,
   output logic [31:0]       data_write_2DM,
   output logic [3:0]        data_byte_en_2DM,
   output logic              MemRead_2DM,
   output logic              MemWrite_2DM,
   input  logic              data_gnt_fDM,
   input  logic              data_rvalid_fDM,
   input  logic [31:0]       data_read_fDM
);

   localparam int unsigned WA_W = ADDR_W - 2;

   mem_state_t        state_q, state_d;
   logic [1:0]        k;
   logic [4:0]        sh_k, sh_rk;
   logic              is_half, is_word, misaligned, load_ok, store_ok;
   logic [31:0]       w_be, rt, load_data, st_data_be, wb_data;
   logic [3:0]        st_be_be;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic              read_req, drain_req, load_done, sb_push, sb_pop;
   logic              sb_full, sb_empty;
   logic [WA_W-1:0]   sb_head_addr;
   logic [31:0]       sb_head_data;
   logic [3:0]        sb_head_be;
   logic              unused_dbg;

   // Debug fields travel with the instruction but are not consumed here
   assign unused_dbg = ^{Instr1_IN, Instr1_PC_IN};

   assign k     = ALU_result1_IN[1:0];
   assign sh_k  = {k, 3'b000};
   assign sh_rk = {~k, 3'b000};
   assign rt    = MemWriteData1_IN;

   // Alignment checking
   assign is_half    = (ALU_Control1_IN == OP_LH) || (ALU_Control1_IN == OP_LHU) ||
                       (ALU_Control1_IN == OP_SH);
   assign is_word    = (ALU_Control1_IN == OP_LW) || (ALU_Control1_IN == OP_SW) ||
                       (ALU_Control1_IN == OP_LL) || (ALU_Control1_IN == OP_SC) ||
                       (ALU_Control1_IN == OP_LWC1);
   assign misaligned = (MemRead1_IN || MemWrite1_IN) &&
                       ((is_half && k[0]) || (is_word && (k != 2'b00)));
   assign load_ok    = MemRead1_IN && !MemWrite1_IN && !misaligned;
   assign store_ok   = MemWrite1_IN && !MemRead1_IN && !misaligned;

   // Load path works on a big-endian view of the returned word
   assign w_be   = BIG_ENDIAN ? data_read_fDM : byte_swap(data_read_fDM);
   assign byte_v = 8'(w_be >> sh_rk);
   assign half_v = k[1] ? w_be[15:0] : w_be[31:16];

   always_comb begin
      load_data = w_be;
      case (ALU_Control1_IN)
         OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_data = {24'h0, byte_v};
         OP_LH:   load_data = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_data = {16'h0, half_v};
         OP_LWL:  load_data = (w_be << sh_k)  | (rt & ~(32'hFFFF_FFFF << sh_k));
         OP_LWR:  load_data = (w_be >> sh_rk) | (rt & ~(32'hFFFF_FFFF >> sh_rk));
         default: load_data = w_be;
      endcase
   end

   // Store lane placement, big-endian view, mirrored below for little-endian
   always_comb begin
      st_be_be   = 4'b1111;
      st_data_be = rt;
      case (ALU_Control1_IN)
         OP_SB: begin
            st_be_be   = 4'b1000 >> k;
            st_data_be = {4{rt[7:0]}};
         end
         OP_SH: begin
            st_be_be   = k[1] ? 4'b0011 : 4'b1100;
            st_data_be = {2{rt[15:0]}};
         end
         OP_SWL: begin
            st_be_be   = 4'b1111 >> k;
            st_data_be = rt >> sh_k;
         end
         OP_SWR: begin
            st_be_be   = 4'b1111 << (~k);
            st_data_be = rt << sh_rk;
         end
         default: begin
            st_be_be   = 4'b1111;
            st_data_be = rt;
         end
      endcase
   end

   mem_store_buffer #(
      .DEPTH (SB_DEPTH),
      .AW    (WA_W)
   ) u_sb (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (sb_push),
      .push_addr (ALU_result1_IN[ADDR_W-1:2]),
      .push_data (BIG_ENDIAN ? st_data_be : byte_swap(st_data_be)),
      .push_be   (BIG_ENDIAN ? st_be_be : be_swap(st_be_be)),
      .pop       (sb_pop),
      .head_addr (sb_head_addr),
      .head_data (sb_head_data),
      .head_be   (sb_head_be),
      .full      (sb_full),
      .empty     (sb_empty)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state, memory requests, buffer strobes and stall.
   // IDLE/LD_DRAIN issue the read themselves once the buffer is empty, so a
   // zero-wait read with an empty buffer completes in the cycle it arrives.
   always_comb begin
      state_d   = state_q;
      read_req  = 1'b0;
      drain_req = 1'b0;
      load_done = 1'b0;
      sb_pop    = 1'b0;
      sb_push   = 1'b0;
      STALL_OUT = 1'b0;
      case (state_q)
         ST_IDLE, ST_LD_DRAIN: begin
            if (!load_ok) begin
               state_d = ST_IDLE;
            end else if (!sb_empty) begin
               state_d = ST_LD_DRAIN;
            end else begin
               read_req = 1'b1;
               if (data_gnt_fDM) state_d = data_rvalid_fDM ? ST_IDLE : ST_LD_WAIT;
               else              state_d = ST_LD_REQ;
            end
         end
         ST_LD_REQ: begin
            read_req = 1'b1;
            if (data_gnt_fDM) state_d = data_rvalid_fDM ? ST_IDLE : ST_LD_WAIT;
         end
         ST_LD_WAIT: begin
            if (data_rvalid_fDM) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (RESET) read_req = 1'b0;
      drain_req = !RESET && !sb_empty &&
                  ((state_q == ST_IDLE) || (state_q == ST_LD_DRAIN));
      sb_pop    = drain_req && data_gnt_fDM;
      load_done = (read_req && data_gnt_fDM && data_rvalid_fDM) ||
                  ((state_q == ST_LD_WAIT) && data_rvalid_fDM);
      sb_push   = !RESET && store_ok && (state_q == ST_IDLE) && (!sb_full || sb_pop);
      if (RESET)         STALL_OUT = 1'b0;
      else if (load_ok)  STALL_OUT = !load_done;
      else if (store_ok) STALL_OUT = !sb_push;
   end

   assign MemRead_2DM      = read_req;
   assign MemWrite_2DM     = drain_req;
   assign data_address_2DM = read_req  ? {ALU_result1_IN[ADDR_W-1:2], 2'b00} :
                             drain_req ? {sb_head_addr, 2'b00} : '0;
   assign data_write_2DM   = drain_req ? sb_head_data : 32'h0;
   assign data_byte_en_2DM = read_req ? 4'b1111 : (drain_req ? sb_head_be : 4'b0000);

   always_comb begin
      wb_data = 32'(ALU_result1_IN);
      if (load_ok)                                          wb_data = load_data;
      else if (store_ok && (ALU_Control1_IN == OP_SC))      wb_data = 32'h1;
   end

   // WB register: takes the instruction when not stalled, else a bubble
   always_ff @(posedge CLK) begin
      if (RESET || STALL_OUT) begin
         WriteRegister1_OUT <= 5'h0;
         RegWrite1_OUT      <= 1'b0;
         WriteData1_OUT     <= 32'h0;
         AddrError_OUT      <= 1'b0;
      end else begin
         WriteRegister1_OUT <= WriteRegister1_IN;
         RegWrite1_OUT      <= RegWrite1_IN && !misaligned;
         WriteData1_OUT     <= wb_data;
         AddrError_OUT      <= misaligned;
      end
   end

endmodule
